// File: rtl/instr_encoder_loader_if.sv
// Request and instruction-memory write bus of the instruction encoder/loader.
// The master issues decoded fields; the slave (loader) drives the memory write port.
interface instr_encoder_loader_if #(
    parameter int ADDR_W = 9
);
    logic              req_valid;
    logic              req_ready;
    logic [2:0]        req_kind;
    logic [2:0]        req_funct3;
    logic [6:0]        req_funct7;
    logic [4:0]        req_rd;
    logic [4:0]        req_rs1;
    logic [4:0]        req_rs2;
    logic [31:0]       req_imm;
    logic              req_last;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;

    modport master (
        output req_valid, req_kind, req_funct3, req_funct7, req_rd, req_rs1,
               req_rs2, req_imm, req_last,
        input  req_ready, imem_we, imem_addr, imem_wdata
    );

    modport slave (
        input  req_valid, req_kind, req_funct3, req_funct7, req_rd, req_rs1,
               req_rs2, req_imm, req_last,
        output req_ready, imem_we, imem_addr, imem_wdata
    );
endinterface

// File: rtl/instr_encoder_loader.sv
// Assembles RV32I words from decoded fields and writes them to consecutive
// instruction-memory addresses, one word per two cycles, for program loading.
module instr_encoder_loader #(
    parameter int ADDR_W    = 9,
    parameter int BASE_ADDR = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    instr_encoder_loader_if.slave bus,
    output logic                 busy,
    output logic                 done,
    output logic                 error,
    output logic [ADDR_W:0]      count
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_ACCEPT,
        S_WRITE,
        S_DONE,
        S_ERR
    } state_t;

    localparam logic [ADDR_W:0] BASE = (ADDR_W+1)'(BASE_ADDR);

    state_t            state_q, state_d;
    logic [ADDR_W:0]   ptr_q, ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic [31:0]       word_q, word_d;
    logic              last_q, last_d;

    logic [31:0]        enc;
    logic               bad;
    logic               ready;
    logic               write_en;
    logic signed [31:0] simm;
    logic               is_shift;

    assign simm     = bus.req_imm;
    assign is_shift = (bus.req_funct3 == 3'b001) || (bus.req_funct3 == 3'b101);

    always_comb begin
        enc = '0;
        unique case (bus.req_kind)
            3'd0: enc = {bus.req_funct7, bus.req_rs2, bus.req_rs1, bus.req_funct3,
                         bus.req_rd, 7'b0110011};
            3'd1: enc = is_shift
                      ? {bus.req_funct7, bus.req_imm[4:0], bus.req_rs1, bus.req_funct3,
                         bus.req_rd, 7'b0010011}
                      : {bus.req_imm[11:0], bus.req_rs1, bus.req_funct3,
                         bus.req_rd, 7'b0010011};
            3'd2: enc = {bus.req_imm[11:0], bus.req_rs1, 3'b010, bus.req_rd, 7'b0000011};
            3'd3: enc = {bus.req_imm[11:5], bus.req_rs2, bus.req_rs1, 3'b010,
                         bus.req_imm[4:0], 7'b0100011};
            3'd4: enc = {bus.req_imm[12], bus.req_imm[10:5], bus.req_rs2, bus.req_rs1,
                         bus.req_funct3, bus.req_imm[4:1], bus.req_imm[11], 7'b1100011};
            3'd5: enc = {bus.req_imm[20], bus.req_imm[10:1], bus.req_imm[11],
                         bus.req_imm[19:12], bus.req_rd, 7'b1101111};
            3'd6: enc = {bus.req_imm[11:0], bus.req_rs1, 3'b000, bus.req_rd, 7'b1100111};
            default: enc = '0;
        endcase
    end

    // Memory is full once every word has been written; no wrap-around.
    always_comb begin
        bad = ptr_q[ADDR_W] | count_q[ADDR_W];
        unique case (bus.req_kind)
            3'd0: ;
            3'd1: begin
                if (is_shift) bad = bad | (simm < 0) | (simm > 32'sd31);
                else          bad = bad | (simm < -32'sd2048) | (simm > 32'sd2047);
            end
            3'd2, 3'd3, 3'd6: bad = bad | (simm < -32'sd2048) | (simm > 32'sd2047);
            3'd4: bad = bad | (simm < -32'sd4096) | (simm > 32'sd4094) | bus.req_imm[0];
            3'd5: bad = bad | (simm < -32'sd1048576) | (simm > 32'sd1048574) | bus.req_imm[0];
            default: bad = 1'b1;
        endcase
    end

    assign ready    = (state_q == S_ACCEPT) && !reset;
    assign write_en = (state_q == S_WRITE) && !reset;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        count_d = count_q;
        word_d  = word_q;
        last_d  = last_q;
        unique case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    state_d = S_ACCEPT;
                    ptr_d   = BASE;
                    count_d = '0;
                end
            end
            S_ACCEPT: begin
                if (bus.req_valid) begin
                    if (bad) begin
                        state_d = S_ERR;
                    end else begin
                        state_d = S_WRITE;
                        word_d  = enc;
                        last_d  = bus.req_last;
                    end
                end
            end
            S_WRITE: begin
                ptr_d   = ptr_q + 1'b1;
                count_d = count_q + 1'b1;
                state_d = last_q ? S_DONE : S_ACCEPT;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            ptr_q   <= BASE;
            count_q <= '0;
            word_q  <= '0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            count_q <= count_d;
            word_q  <= word_d;
            last_q  <= last_d;
        end
    end

    assign bus.req_ready  = ready;
    assign bus.imem_we    = write_en;
    assign bus.imem_addr  = write_en ? ptr_q[ADDR_W-1:0] : '0;
    assign bus.imem_wdata = write_en ? word_q : '0;

    assign busy  = (state_q == S_ACCEPT) || (state_q == S_WRITE);
    assign done  = (state_q == S_DONE);
    assign error = (state_q == S_ERR);
    assign count = count_q;
endmodule

// File: tb/tb_instr_encoder_loader.sv
// Scoreboard bench for instr_encoder_loader: directed scenarios plus randomized
// sessions checked against an arithmetic reference encoder.
module tb_instr_encoder_loader;
    localparam int AW  = 2;
    localparam int CAP = 1 << AW;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [31:0]   data;
    } wr_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          busy, done, error;
    logic [AW:0]   count;

    instr_encoder_loader_if #(.ADDR_W(AW)) bus();

    instr_encoder_loader #(.ADDR_W(AW), .BASE_ADDR(0)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .bus   (bus),
        .busy  (busy),
        .done  (done),
        .error (error),
        .count (count)
    );

    always #5 clk = ~clk;

    int  checks = 0;
    int  errors = 0;
    wr_t sb[$];

    bit  m_active = 0;
    bit  m_done   = 0;
    bit  m_err    = 0;
    int  m_count  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit m_legal(input logic [2:0] kind, input logic [2:0] f3, input int imm);
        case (kind)
            3'd0: return 1;
            3'd1: if (f3 == 3'd1 || f3 == 3'd5) return imm >= 0 && imm <= 31;
                  else return imm >= -2048 && imm <= 2047;
            3'd2, 3'd3, 3'd6: return imm >= -2048 && imm <= 2047;
            3'd4: return imm >= -4096 && imm <= 4094 && (imm % 2 == 0);
            3'd5: return imm >= -1048576 && imm <= 1048574 && (imm % 2 == 0);
            default: return 0;
        endcase
    endfunction

    function automatic logic [31:0] fld(input logic [31:0] v, input int lo, input int w, input int pos);
        return ((v >> lo) & ((32'd1 << w) - 32'd1)) << pos;
    endfunction

    function automatic logic [31:0] m_encode(input logic [2:0] kind, input logic [2:0] f3,
                                             input logic [6:0] f7, input logic [4:0] rd,
                                             input logic [4:0] rs1, input logic [4:0] rs2,
                                             input int imm);
        logic [31:0] u = imm;
        logic [31:0] regs = (32'(rd) << 7) | (32'(rs1) << 15);
        case (kind)
            3'd0: return 32'h33 | regs | (32'(f3) << 12) | (32'(rs2) << 20) | (32'(f7) << 25);
            3'd1: if (f3 == 3'd1 || f3 == 3'd5)
                      return 32'h13 | regs | (32'(f3) << 12) | fld(u, 0, 5, 20) | (32'(f7) << 25);
                  else
                      return 32'h13 | regs | (32'(f3) << 12) | fld(u, 0, 12, 20);
            3'd2: return 32'h03 | regs | (32'd2 << 12) | fld(u, 0, 12, 20);
            3'd6: return 32'h67 | regs | fld(u, 0, 12, 20);
            3'd3: return 32'h23 | fld(u, 0, 5, 7) | (32'd2 << 12) | (32'(rs1) << 15)
                         | (32'(rs2) << 20) | fld(u, 5, 7, 25);
            3'd4: return 32'h63 | fld(u, 11, 1, 7) | fld(u, 1, 4, 8) | (32'(f3) << 12)
                         | (32'(rs1) << 15) | (32'(rs2) << 20) | fld(u, 5, 6, 25) | fld(u, 12, 1, 31);
            3'd5: return 32'h6F | (32'(rd) << 7) | fld(u, 12, 8, 12) | fld(u, 11, 1, 20)
                         | fld(u, 1, 10, 21) | fld(u, 20, 1, 31);
            default: return 32'h0;
        endcase
    endfunction

    function automatic int gen_imm(input logic [2:0] kind, input logic [2:0] f3);
        int lo, hi, v, r;
        bit even = 0;
        case (kind)
            3'd1: if (f3 == 3'd1 || f3 == 3'd5) begin lo = 0; hi = 31; end
                  else begin lo = -2048; hi = 2047; end
            3'd2, 3'd3, 3'd6: begin lo = -2048; hi = 2047; end
            3'd4: begin lo = -4096; hi = 4094; even = 1; end
            3'd5: begin lo = -1048576; hi = 1048574; even = 1; end
            default: return int'($urandom);
        endcase
        v = lo + int'($urandom_range(0, hi - lo));
        if (even) v = v & ~1;
        r = int'($urandom_range(0, 9));
        case (r)
            0: v = lo;
            1: v = hi;
            2: v = lo - (even ? 2 : 1);
            3: v = hi + (even ? 2 : 1);
            4: if (even) v = v | 1;
            default: ;
        endcase
        return v;
    endfunction

    task automatic handshake(input logic [2:0] kind, input logic [2:0] f3, input logic [6:0] f7,
                             input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                             input int imm, input bit last);
        bit got = 0;
        bus.req_kind   = kind;
        bus.req_funct3 = f3;
        bus.req_funct7 = f7;
        bus.req_rd     = rd;
        bus.req_rs1    = rs1;
        bus.req_rs2    = rs2;
        bus.req_imm    = imm;
        bus.req_last   = last;
        bus.req_valid  = 1'b1;
        for (int c = 0; c < 20 && !got; c++) begin
            @(negedge clk);
            if (bus.req_ready === 1'b1) begin
                @(posedge clk);
                #1;
                got = 1;
            end
        end
        bus.req_valid = 1'b0;
        if (!got) chk("handshake_timeout", 64'd0, 64'd1);
    endtask

    task automatic check_status(input string tag);
        bit b = m_active && !m_done && !m_err;
        chk({tag, "_busy"}, 64'(busy), 64'(b));
        chk({tag, "_ready"}, 64'(bus.req_ready), 64'(b));
        chk({tag, "_done"}, 64'(done), 64'(m_done));
        chk({tag, "_error"}, 64'(error), 64'(m_err));
        chk({tag, "_count"}, 64'(count), 64'(m_count));
    endtask

    task automatic issue(input string tag, input logic [2:0] kind, input logic [2:0] f3,
                         input logic [6:0] f7, input logic [4:0] rd, input logic [4:0] rs1,
                         input logic [4:0] rs2, input int imm, input bit last,
                         input bit use_want = 0, input logic [31:0] want = 32'h0);
        wr_t w;
        if (m_legal(kind, f3, imm) && m_count < CAP) begin
            w.addr = m_count[AW-1:0];
            w.data = use_want ? want : m_encode(kind, f3, f7, rd, rs1, rs2, imm);
            sb.push_back(w);
            m_count++;
            if (last) m_done = 1;
        end else begin
            m_err = 1;
        end
        handshake(kind, f3, f7, rd, rs1, rs2, imm, last);
        @(posedge clk);
        #1;
        check_status(tag);
    endtask

    task automatic do_start();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        if (!m_active || m_done || m_err) begin
            m_active = 1;
            m_done   = 0;
            m_err    = 0;
            m_count  = 0;
        end
    endtask

    task automatic check_zero_outputs(input string tag);
        check_status(tag);
        chk({tag, "_we"}, 64'(bus.imem_we), 64'd0);
        chk({tag, "_addr"}, 64'(bus.imem_addr), 64'd0);
        chk({tag, "_wdata"}, 64'(bus.imem_wdata), 64'd0);
    endtask

    // Monitor: every write strobe must match the oldest expected write.
    initial begin
        wr_t e;
        forever begin
            @(negedge clk);
            if (bus.imem_we === 1'b1) begin
                if (sb.size() == 0) begin
                    chk("unexpected_write", 64'(bus.imem_addr), 64'hFFFF);
                end else begin
                    e = sb.pop_front();
                    chk("imem_addr", 64'(bus.imem_addr), 64'(e.addr));
                    chk("imem_wdata", 64'(bus.imem_wdata), 64'(e.data));
                end
            end
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.req_valid  = 1'b0;
        bus.req_kind   = '0;
        bus.req_funct3 = '0;
        bus.req_funct7 = '0;
        bus.req_rd     = '0;
        bus.req_rs1    = '0;
        bus.req_rs2    = '0;
        bus.req_imm    = '0;
        bus.req_last   = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        check_zero_outputs("reset");

        do_start();
        check_status("start");
        issue("r_add", 3'd0, 3'd0, 7'd0, 5'd3, 5'd1, 5'd2, 0, 0, 1, 32'h002081B3);
        issue("lw", 3'd2, 3'd0, 7'd0, 5'd5, 5'd2, 5'd0, 8, 0, 1, 32'h00812283);
        issue("sw_last", 3'd3, 3'd0, 7'd0, 5'd0, 5'd2, 5'd6, -4, 1, 1, 32'hFE612E23);

        do_start();
        issue("beq", 3'd4, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, -8, 0, 1, 32'hFE208CE3);
        issue("br_odd", 3'd4, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 3, 0);

        do_start();
        issue("fill0", 3'd0, 3'd7, 7'h20, 5'd4, 5'd5, 5'd6, 0, 0);
        do_start();
        check_status("start_ignored");
        issue("fill1", 3'd5, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, -1048576, 0);
        issue("fill2", 3'd6, 3'd0, 7'd0, 5'd1, 5'd7, 5'd0, 2047, 0);
        issue("fill3", 3'd1, 3'd0, 7'd0, 5'd2, 5'd3, 5'd0, -2048, 0);
        issue("overflow", 3'd0, 3'd0, 7'd0, 5'd1, 5'd1, 5'd1, 0, 1);

        do_start();
        issue("shift_big", 3'd1, 3'd1, 7'h20, 5'd1, 5'd1, 5'd0, 40, 0);
        do_start();
        issue("shift_ok", 3'd1, 3'd1, 7'h20, 5'd1, 5'd1, 5'd0, 5, 1, 1, 32'h40509093);

        do_start();
        issue("jal_max", 3'd5, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 1048574, 0);
        issue("kind7", 3'd7, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 0, 0);

        // Reset lands in the write cycle: the write must not appear.
        do_start();
        handshake(3'd0, 3'd0, 7'd0, 5'd9, 5'd9, 5'd9, 0, 0);
        reset = 1'b1;
        #1;
        chk("we_during_reset", 64'(bus.imem_we), 64'd0);
        @(posedge clk);
        #1;
        reset    = 1'b0;
        m_active = 0;
        m_done   = 0;
        m_err    = 0;
        m_count  = 0;
        check_zero_outputs("after_reset");
        do_start();
        issue("post_reset", 3'd0, 3'd0, 7'd0, 5'd3, 5'd1, 5'd2, 0, 1, 1, 32'h002081B3);

        for (int s = 0; s < 40; s++) begin
            int n;
            do_start();
            n = int'($urandom_range(1, 6));
            for (int i = 0; i < n; i++) begin
                logic [2:0] kind, f3;
                logic [6:0] f7;
                int r;
                if (m_err || m_done) break;
                r    = int'($urandom_range(0, 15));
                kind = (r < 14) ? 3'(r % 7) : 3'd7;
                f3   = 3'($urandom);
                f7   = 7'($urandom);
                issue("rand", kind, f3, f7, 5'($urandom), 5'($urandom), 5'($urandom),
                      gen_imm(kind, f3), (i == n - 1));
            end
        end

        repeat (5) @(posedge clk);
        #1;
        chk("sb_drained", 64'(sb.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
